fft_frame_io: RTL and testbench

- Frame I/O sequencer that owns the in-place FFT working RAM before and after each transform.
- Accepts a stream of N = 2^ADDR_WIDTH complex samples and writes them in bit-reversed address order.
- Pulses start to the FFT engine, waits for fft_done, then reads results in natural order out as a valid/ready stream with backpressure.
- Sits between the sample source/result sink and the RAM mux in front of the FFT controller.

---
 rtl/fft_frame_io.sv | 179 +++++++++++++++++
 tb/tb_fft_frame_io.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_io.sv
// fft_frame_io
// Frame I/O sequencer for an in-place FFT working RAM. It takes one frame of
// N = 2^ADDR_WIDTH complex samples and writes them at bit-reversed addresses,
// starts the FFT engine, waits for it to finish, then streams the results out
// in natural order with valid/ready backpressure.
//
// Ports
//   i_clk, i_rst_n            system clock, asynchronous active-low reset
//   i_s_valid/o_s_ready       input sample handshake, i_s_data = {imag, real}
//   o_ram_sel                 1: this block owns the RAM ports, 0: FFT engine
//   o_ram_wen/waddr/wdata     RAM write port (registered, latency 1)
//   o_ram_ren/raddr           RAM read port, i_ram_rdata valid one cycle later
//   o_fft_start, i_fft_done   one-cycle start / completion pulses
//   o_m_valid/i_m_ready       result handshake, o_m_data = {imag, real}
//   o_m_last                  marks the result read from address N-1
//   o_busy                    high while not loading
//
// state  | meaning
// LOAD   | accept samples, write them bit-reversed into the RAM
// KICK   | last write on the RAM port, start pulse follows
// WAIT   | FFT engine owns the RAM until fft_done
// UNLOAD | read results 0..N-1 through a 2-entry output FIFO

module fft_frame_io #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_s_valid,
    output logic                      o_s_ready,
    input  logic [2*DATA_WIDTH-1:0]   i_s_data,
    output logic                      o_ram_sel,
    output logic                      o_ram_wen,
    output logic [ADDR_WIDTH-1:0]     o_ram_waddr,
    output logic [2*DATA_WIDTH-1:0]   o_ram_wdata,
    output logic                      o_ram_ren,
    output logic [ADDR_WIDTH-1:0]     o_ram_raddr,
    input  logic [2*DATA_WIDTH-1:0]   i_ram_rdata,
    output logic                      o_fft_start,
    input  logic                      i_fft_done,
    output logic                      o_m_valid,
    input  logic                      i_m_ready,
    output logic [2*DATA_WIDTH-1:0]   o_m_data,
    output logic                      o_m_last,
    output logic                      o_busy
);

    localparam int DW2 = 2 * DATA_WIDTH;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_KICK   = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_UNLOAD = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_wr_cnt;
    logic [ADDR_WIDTH:0]   r_rd_cnt;      // MSB set once all N reads are issued
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DW2-1:0]        r_wdata;
    logic                  r_fft_start;
    logic                  r_rd_pend;
    logic                  r_rd_pend_last;
    logic [DW2:0]          r_fifo [2];    // {last, data}
    logic                  r_fifo_wptr;
    logic                  r_fifo_rptr;
    logic [1:0]            r_fifo_cnt;

    logic                  w_s_hs;
    logic                  w_m_pop;
    logic                  w_m_done;
    logic                  w_rd_issue;
    logic [2:0]            w_occupancy;
    logic [DW2:0]          w_head;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = a[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

    assign w_head   = r_fifo[r_fifo_rptr];
    assign w_s_hs   = (r_state == ST_LOAD) && i_s_valid;
    assign w_m_pop  = (r_fifo_cnt != 2'd0) && i_m_ready;
    assign w_m_done = w_m_pop && w_head[DW2];

    // Occupancy counts the entry leaving this cycle as already gone, so a
    // continuously ready sink sees one result per cycle while the FIFO plus
    // the read in flight can never exceed two entries.
    assign w_occupancy = {1'b0, r_fifo_cnt} - {2'b00, w_m_pop} + {2'b00, r_rd_pend};
    assign w_rd_issue  = (r_state == ST_UNLOAD) && !r_rd_cnt[ADDR_WIDTH] &&
                         (w_occupancy < 3'd2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:   if (w_s_hs && (r_wr_cnt == {ADDR_WIDTH{1'b1}})) r_state <= ST_KICK;
                ST_KICK:   r_state <= ST_WAIT;
                ST_WAIT:   if (i_fft_done) r_state <= ST_UNLOAD;
                ST_UNLOAD: if (w_m_done) r_state <= ST_LOAD;
                default:   r_state <= ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_cnt    <= '0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_fft_start <= 1'b0;
        end else begin
            r_wen       <= w_s_hs;
            r_fft_start <= (r_state == ST_KICK);
            if (w_s_hs) begin
                r_waddr  <= bitrev(r_wr_cnt);
                r_wdata  <= i_s_data;
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end else if (w_m_done) begin
                r_wr_cnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_cnt       <= '0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
        end else begin
            r_rd_pend      <= w_rd_issue;
            r_rd_pend_last <= w_rd_issue && (r_rd_cnt[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});
            if (w_m_done) begin
                r_rd_cnt <= '0;
            end else if (w_rd_issue) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_fifo_wptr <= 1'b0;
            r_fifo_rptr <= 1'b0;
            r_fifo_cnt  <= 2'd0;
        end else begin
            if (r_rd_pend) begin
                r_fifo[r_fifo_wptr] <= {r_rd_pend_last, i_ram_rdata};
                r_fifo_wptr         <= ~r_fifo_wptr;
            end
            if (w_m_pop) begin
                r_fifo_rptr <= ~r_fifo_rptr;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, r_rd_pend} - {1'b0, w_m_pop};
        end
    end

    assign o_s_ready   = (r_state == ST_LOAD);
    assign o_ram_sel   = (r_state != ST_WAIT);
    assign o_busy      = (r_state != ST_LOAD);
    assign o_ram_wen   = r_wen;
    assign o_ram_waddr = r_waddr;
    assign o_ram_wdata = r_wdata;
    assign o_ram_ren   = w_rd_issue;
    assign o_ram_raddr = r_rd_cnt[ADDR_WIDTH-1:0];
    assign o_fft_start = r_fft_start;
    assign o_m_valid   = (r_fifo_cnt != 2'd0);
    assign o_m_data    = w_head[DW2-1:0];
    assign o_m_last    = o_m_valid && w_head[DW2];

endmodule

// File: tb/tb_fft_frame_io.sv
// tb_fft_frame_io
// Self-checking bench for fft_frame_io. A behavioural RAM and a stand-in FFT
// engine (which overwrites the RAM with a known result frame) surround the DUT.
// Samples and results are held in reference arrays; expected write addresses
// come from an arithmetic bit reversal.

module tb_fft_frame_io;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [2*DW-1:0] s_data = '0;
    logic          ram_sel, ram_wen, ram_ren;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [2*DW-1:0] ram_wdata;
    logic [2*DW-1:0] ram_rdata = '0;
    logic          fft_start;
    logic          fft_done = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [2*DW-1:0] m_data;
    logic          m_last, busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2*DW-1:0] mem   [N];
    logic [2*DW-1:0] x_ref [N];
    logic [2*DW-1:0] y_ref [N];
    logic            eng_fill = 1'b0;

    fft_frame_io #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
        .o_ram_sel(ram_sel), .o_ram_wen(ram_wen), .o_ram_waddr(ram_waddr),
        .o_ram_wdata(ram_wdata), .o_ram_ren(ram_ren), .o_ram_raddr(ram_raddr),
        .i_ram_rdata(ram_rdata), .o_fft_start(fft_start), .i_fft_done(fft_done),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
        .o_m_last(m_last), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Working RAM; the stand-in engine replaces the whole frame in one cycle.
    always @(posedge clk) begin
        if (eng_fill) begin
            for (int a = 0; a < N; a++) mem[a] <= y_ref[a];
        end else if (ram_sel && ram_wen) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_sel && ram_ren) ram_rdata <= mem[ram_raddr];
    end

    function automatic int rev(input int k);
        int r = 0;
        int v = k;
        for (int b = 0; b < AW; b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({s_ready, ram_sel, busy, m_valid, m_last, fft_start, ram_wen, ram_ren} !== 8'b1100_0000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 11000000",
                     {s_ready, ram_sel, busy, m_valid, m_last, fft_start, ram_wen, ram_ren});
        end
        n_cmp++;
        if ({ram_waddr, ram_wdata, ram_raddr, m_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got %h want 0", {ram_waddr, ram_wdata, ram_raddr, m_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic load_frame(input bit gapped, input bit ramp);
        int  k = 0;
        int  cyc = 0;
        bit  prev_hs = 1'b0;
        int  prev_k = 0;
        for (int a = 0; a < N; a++) x_ref[a] = ramp ? (2*DW)'(a) : (2*DW)'($urandom);
        while (k < N && cyc < 4 * N) begin
            n_cmp++;
            if (s_ready !== 1'b1 || busy !== 1'b0 || fft_start !== 1'b0) begin
                n_bad++;
                $display("FAIL load_ready k=%0d got rdy=%b busy=%b start=%b want 1 0 0",
                         k, s_ready, busy, fft_start);
            end
            n_cmp++;
            if (ram_wen !== prev_hs ||
                (prev_hs && (ram_waddr !== AW'(rev(prev_k)) || ram_wdata !== x_ref[prev_k]))) begin
                n_bad++;
                $display("FAIL load_write k=%0d got wen=%b addr=%0d data=%h want wen=%b addr=%0d data=%h",
                         prev_k, ram_wen, ram_waddr, ram_wdata, prev_hs, rev(prev_k), x_ref[prev_k]);
            end
            s_valid = gapped ? (cyc % 2 == 0) : 1'b1;
            s_data  = s_valid ? x_ref[k] : (2*DW)'($urandom);
            prev_hs = s_valid;
            prev_k  = k;
            if (s_valid) k++;
            cyc++;
            step();
        end
        s_valid = 1'b0;
        n_cmp++;
        if (k < N) begin
            n_bad++;
            $display("FAIL load_timeout got %0d samples want %0d", k, N);
        end
        // KICK cycle: final write on the port
        n_cmp++;
        if (ram_wen !== 1'b1 || ram_waddr !== AW'(N-1) || ram_wdata !== x_ref[N-1] ||
            s_ready !== 1'b0 || ram_sel !== 1'b1 || fft_start !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL kick_cycle got wen=%b addr=%0d rdy=%b sel=%b start=%b busy=%b want 1 %0d 0 1 0 1",
                     ram_wen, ram_waddr, s_ready, ram_sel, fft_start, busy, N-1);
        end
    endtask

    task automatic test_kick_wait();
        int bad = 0;
        s_valid = 1'b1;
        s_data  = (2*DW)'($urandom);
        step();
        n_cmp++;
        if (fft_start !== 1'b1 || ram_sel !== 1'b0 || s_ready !== 1'b0 || ram_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL start_pulse got start=%b sel=%b rdy=%b wen=%b want 1 0 0 0",
                     fft_start, ram_sel, s_ready, ram_wen);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if ({fft_start, ram_sel, s_ready, ram_wen, ram_ren, busy} !== 6'b000001) begin
                n_bad++;
                $display("FAIL wait_idle cyc=%0d got %b want 000001", i,
                         {fft_start, ram_sel, s_ready, ram_wen, ram_ren, busy});
            end
        end
        s_valid = 1'b0;
        for (int k = 0; k < N; k++) if (mem[rev(k)] !== x_ref[k]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL ram_contents got %0d wrong words want 0", bad);
        end
    endtask

    // mode 0: ready held, ramp results; 1: ready 1,0,0,1; 2: random ready
    task automatic unload_frame(input int mode, input int abort_at);
        int idx = 0;
        int issued = 0;
        int cyc = 0;
        int first_v = -1;
        int last_cyc = -1;
        bit stalled = 1'b0;
        logic [2*DW-1:0] held = '0;
        for (int a = 0; a < N; a++) y_ref[a] = (mode == 0) ? (2*DW)'(a) : (2*DW)'($urandom);
        eng_fill = 1'b1;
        step();
        eng_fill = 1'b0;
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        n_cmp++;
        if (ram_sel !== 1'b1 || busy !== 1'b1 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL unload_entry got sel=%b busy=%b valid=%b want 1 1 0", ram_sel, busy, m_valid);
        end
        while (idx < N && cyc < 8 * N) begin
            case (mode)
                1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       m_ready = 1'($urandom);
                default: m_ready = 1'b1;
            endcase
            #1;
            if (stalled) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    n_bad++;
                    $display("FAIL stall_hold idx=%0d got v=%b d=%h want 1 %h", idx, m_valid, m_data, held);
                end
            end
            if (m_valid) begin
                if (first_v < 0) first_v = cyc;
                n_cmp++;
                if (m_data !== y_ref[idx] || m_last !== (idx == N-1)) begin
                    n_bad++;
                    $display("FAIL result idx=%0d got d=%h last=%b want d=%h last=%b",
                             idx, m_data, m_last, y_ref[idx], (idx == N-1));
                end
            end
            if (ram_ren) begin
                n_cmp++;
                if (ram_raddr !== AW'(issued) || issued >= N) begin
                    n_bad++;
                    $display("FAIL read_addr got %0d want %0d", ram_raddr, issued);
                end
                issued++;
            end
            stalled = m_valid && !m_ready;
            held    = m_data;
            if (m_valid && m_ready) begin
                idx++;
                if (idx == N) last_cyc = cyc;
            end
            if (ram_ren) begin
                n_cmp++;
                if (issued - idx > 2) begin
                    n_bad++;
                    $display("FAIL fifo_space got %0d outstanding want <=2", issued - idx);
                end
            end
            cyc++;
            step();
            if (abort_at > 0 && idx == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({s_ready, ram_sel, busy, m_valid, m_last, fft_start, ram_wen, ram_ren} !== 8'b1100_0000 ||
                    m_data !== '0) begin
                    n_bad++;
                    $display("FAIL async_reset got %b d=%h want 11000000 d=0",
                             {s_ready, ram_sel, busy, m_valid, m_last, fft_start, ram_wen, ram_ren}, m_data);
                end
                m_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                step();
                return;
            end
        end
        m_ready = 1'b0;
        n_cmp++;
        if (idx != N) begin
            n_bad++;
            $display("FAIL unload_timeout got %0d results want %0d", idx, N);
        end
        if (mode == 0) begin
            n_cmp++;
            if (first_v != 2 || last_cyc != N + 1) begin
                n_bad++;
                $display("FAIL throughput got first=%0d last=%0d want 2 %0d", first_v, last_cyc, N + 1);
            end
        end
        n_cmp++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || ram_sel !== 1'b1 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL back_to_load got rdy=%b busy=%b sel=%b v=%b want 1 0 1 0",
                     s_ready, busy, ram_sel, m_valid);
        end
    endtask

    task automatic test_early_done();
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        step();
        n_cmp++;
        if ({s_ready, busy, ram_sel, ram_ren, fft_start, m_valid} !== 6'b101000) begin
            n_bad++;
            $display("FAIL early_done got %b want 101000",
                     {s_ready, busy, ram_sel, ram_ren, fft_start, m_valid});
        end
    endtask

    initial begin
        test_reset();
        // ramp frame, ready held
        load_frame(1'b0, 1'b1);
        test_kick_wait();
        unload_frame(0, 0);
        test_early_done();
        // gapped load, 1,0,0,1 backpressure
        load_frame(1'b1, 1'b0);
        test_kick_wait();
        unload_frame(1, 0);
        // reset after the 100th result
        load_frame(1'b0, 1'b0);
        test_kick_wait();
        unload_frame(2, 100);
        // next frame after reset, back to back with random backpressure
        load_frame(1'b0, 1'b0);
        test_kick_wait();
        unload_frame(2, 0);
        load_frame(1'b1, 1'b0);
        test_kick_wait();
        unload_frame(0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
